serial_cmd_sequencer: RTL and testbench
=======================================

// Module: serial_cmd_sequencer
// PURPOSE
//  Frames command packets arriving on the UART byte stream (opcode + 4 payload bytes), dispatches them to a compute core
//  via a start/done handshake, and serializes the 32-bit result back onto the UART TX byte interface.
//  Sits between serial_rx/serial_tx and the compute datapath. Sole owner of the tx_data/new_tx_data port.
// PARAMETERS
//  OPC_RUN      8'h68 ("h")  opcode: 4-byte operand -> core -> 4-byte result
//  OPC_PING     8'h70 ("p")  opcode: no payload, no core; reply single byte ACK_CHAR
//  ACK_CHAR     8'h6B ("k")  ping reply byte
//  NAK_CHAR     8'h3F ("?")  reply byte for unknown opcode
//  TIMEOUT_CYC  1000000      max idle cycles between payload bytes before frame is discarded (>=2)
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst          in   1   synchronous, active-high reset
//  rx_data      in   8   received byte, valid when new_rx_data=1
//  new_rx_data  in   1   1-cycle strobe, one per received byte
//  tx_data      out  8   byte to transmit, valid with new_tx_data
//  new_tx_data  out  1   1-cycle transmit strobe
//  tx_busy      in   1   transmitter busy; no strobe while high
//  core_start   out  1   1-cycle start pulse to compute core
//  core_opcode  out  8   opcode of dispatched command, stable start..done
//  core_operand out  32  assembled operand, stable start..done
//  core_done    in   1   1-cycle completion strobe from core
//  core_result  in   32  core result, valid when core_done=1
//  error        out  1   1-cycle pulse on timeout or overrun
//  ledout       out  8   {overrun_sticky, timeout_sticky, nak_sticky, 1'b0, cmd_count[3:0]}
// BEHAVIOUR
//  Reset: state=IDLE; tx_data=0, new_tx_data=0, core_start=0, core_opcode=0, core_operand=0, error=0, ledout=0.
//  rst at any time aborts: partial frame dropped, core_start/new_tx_data not issued, stickies and count cleared.
//  States: IDLE, RX_PAYLOAD, DISPATCH, WAIT_CORE, TX_RESP, TX_ONE.
//  IDLE: on new_rx_data: OPC_RUN -> RX_PAYLOAD (byte_idx=0); OPC_PING -> TX_ONE(ACK_CHAR);
//    other -> TX_ONE(NAK_CHAR), set nak_sticky.
//  RX_PAYLOAD: each strobe stores byte little-endian (1st byte -> operand[7:0]); after 4th -> DISPATCH.
//    Gap counter resets on each strobe; reaching TIMEOUT_CYC-1 -> discard, error pulse, timeout_sticky, IDLE, no TX.
//  DISPATCH: core_start=1 for exactly one cycle (cycle after 4th byte sampled) -> WAIT_CORE.
//  WAIT_CORE: wait indefinitely for core_done; capture core_result that cycle -> TX_RESP. No core timeout.
//  TX_RESP: send result bytes [7:0],[15:8],[23:16],[31:24] in order; then cmd_count++ (wraps 15->0), IDLE.
//  TX_ONE: send one byte -> IDLE (ping also increments cmd_count; NAK does not).
//  TX rule: strobe only in a cycle where tx_busy=0; after each strobe one mandatory guard cycle
//    (no strobe, tx_busy ignored) so serial_tx can raise busy. Earliest first result strobe: cycle after core_done.
//  Overrun: new_rx_data in DISPATCH/WAIT_CORE/TX_RESP/TX_ONE -> byte dropped, error pulse, overrun_sticky.
//  core_done outside WAIT_CORE ignored. Same-cycle core_done and new_rx_data in WAIT_CORE: done taken, byte = overrun.
// STRUCTURE
//  Package serial_cmd_pkg: opcode/ACK/NAK constants, state encoding, PAYLOAD_BYTES=4.
//  Sub-module tx_byte_sender: loads 1..4 bytes + count, runs the tx_busy/guard-cycle handshake, returns done pulse.
//  Top keeps the frame FSM, gap counter, operand register, stickies and cmd_count.
// TESTING
//  "h",B1,08,00,00 -> core_start 1 cyc after last byte, operand=0x000008B1; core returns 0x12345678 ->
//    TX 78,56,34,12.
//  "h",01,FF,FF,FF -> operand=0xFFFFFF01; result 0xDEADBEEF with tx_busy held 20 cyc per byte ->
//    EF,BE,AD,DE, one strobe per byte, none while busy.
//  "p" -> single TX 0x6B, no core_start, ledout[3:0]=1; "z" -> TX 0x3F, ledout[5]=1, count unchanged.
//  TIMEOUT_CYC=16: "h",01,02 then silence -> error pulse at gap 15, ledout[6]=1, no TX; next "p" answered normally.
//  Byte strobed during WAIT_CORE -> error pulse, ledout[7]=1, result still sent intact.
//  rst in WAIT_CORE then core_done -> ignored, no TX; 17 pings -> ledout[3:0] wraps to 1.

Source files
------------

// File: rtl/serial_cmd_pkg.sv
// Shared constants and state encodings for the serial command sequencer.
package serial_cmd_pkg;

    localparam logic [7:0] OPC_RUN  = 8'h68;  // "h": 4-byte operand -> core -> 4-byte result
    localparam logic [7:0] OPC_PING = 8'h70;  // "p": single-byte ACK reply
    localparam logic [7:0] ACK_CHAR = 8'h6B;  // "k"
    localparam logic [7:0] NAK_CHAR = 8'h3F;  // "?"

    localparam int PAYLOAD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_PAYLOAD,
        ST_DISPATCH,
        ST_WAIT_CORE,
        ST_TX_RESP,
        ST_TX_ONE
    } state_e;

    typedef enum logic [1:0] {
        SND_IDLE,
        SND_SEND,
        SND_GUARD
    } snd_state_e;

endpackage

// File: rtl/tx_byte_sender.sv
// Serializes 1..4 bytes (LSB first) onto the UART TX strobe interface,
// honouring tx_busy and inserting one guard cycle after every strobe.
//
//  state     | meaning
//  ----------+-----------------------------------------------------
//  SND_IDLE  | nothing queued, waiting for load
//  SND_SEND  | byte pending; strobe in the first cycle tx_busy=0
//  SND_GUARD | mandatory gap after a strobe; done when queue empty
module tx_byte_sender
    import serial_cmd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_bytes,
    input  logic [2:0]  load_count,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        new_tx_data,
    output logic        done
);

    snd_state_e  state_q, state_d;
    logic [31:0] shift_q, shift_d;
    logic [2:0]  remaining_q, remaining_d;

    // State, shift register and byte counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SND_IDLE;
            shift_q     <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            remaining_q <= remaining_d;
        end
    end

    // Next-state: load, strobe when not busy, then guard
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        remaining_d = remaining_q;
        case (state_q)
            SND_IDLE: begin
                if (load) begin
                    shift_d     = load_bytes;
                    remaining_d = load_count;
                    state_d     = SND_SEND;
                end
            end
            SND_SEND: begin
                if (!tx_busy) begin
                    shift_d     = {8'h00, shift_q[31:8]};
                    remaining_d = remaining_q - 3'd1;
                    state_d     = SND_GUARD;
                end
            end
            SND_GUARD: begin
                state_d = (remaining_q == 3'd0) ? SND_IDLE : SND_SEND;
            end
            default: state_d = SND_IDLE;
        endcase
    end

    // Outputs: the low byte of the shifter is always the next byte to send
    always_comb begin
        tx_data     = shift_q[7:0];
        new_tx_data = (state_q == SND_SEND) && !tx_busy;
        done        = (state_q == SND_GUARD) && (remaining_q == 3'd0);
    end

endmodule

// File: rtl/serial_cmd_sequencer.sv
// Frames opcode + payload commands from the UART RX stream, dispatches RUN
// commands to the compute core and returns replies through tx_byte_sender.
//
//  state         | meaning
//  --------------+----------------------------------------------------
//  ST_IDLE       | waiting for an opcode byte
//  ST_RX_PAYLOAD | collecting 4 operand bytes, gap timer armed
//  ST_DISPATCH   | one-cycle core_start
//  ST_WAIT_CORE  | waiting (unbounded) for core_done
//  ST_TX_RESP    | sending 4 result bytes
//  ST_TX_ONE     | sending single ACK/NAK byte
module serial_cmd_sequencer
    import serial_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        new_rx_data,
    output logic [7:0]  tx_data,
    output logic        new_tx_data,
    input  logic        tx_busy,
    output logic        core_start,
    output logic [7:0]  core_opcode,
    output logic [31:0] core_operand,
    input  logic        core_done,
    input  logic [31:0] core_result,
    output logic        error,
    output logic [7:0]  ledout
);

    localparam int              GAP_W    = $clog2(TIMEOUT_CYC);
    // Gap timer counts down from here; hitting zero without a byte means
    // TIMEOUT_CYC-1 idle cycles have elapsed since the last strobe.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(TIMEOUT_CYC - 1);

    state_e           state_q, state_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [31:0]      operand_q, operand_d;
    logic [7:0]       opcode_q, opcode_d;
    logic             ping_q, ping_d;
    logic             ovr_q, ovr_d;
    logic             tmo_q, tmo_d;
    logic             nak_q, nak_d;
    logic [3:0]       cnt_q, cnt_d;

    logic             overrun_hit;
    logic             timeout_hit;
    logic             snd_load;
    logic [31:0]      snd_bytes;
    logic [2:0]       snd_count;
    logic             snd_done;

    tx_byte_sender u_sender (
        .clk         (clk),
        .rst         (rst),
        .load        (snd_load),
        .load_bytes  (snd_bytes),
        .load_count  (snd_count),
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .done        (snd_done)
    );

    // State register plus frame datapath and status flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= '0;
            gap_q      <= '0;
            operand_q  <= '0;
            opcode_q   <= '0;
            ping_q     <= 1'b0;
            ovr_q      <= 1'b0;
            tmo_q      <= 1'b0;
            nak_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            gap_q      <= gap_d;
            operand_q  <= operand_d;
            opcode_q   <= opcode_d;
            ping_q     <= ping_d;
            ovr_q      <= ovr_d;
            tmo_q      <= tmo_d;
            nak_q      <= nak_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state: frame parsing, dispatch, reply sequencing
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        gap_d      = gap_q;
        operand_d  = operand_q;
        opcode_d   = opcode_q;
        ping_d     = ping_q;
        ovr_d      = ovr_q | overrun_hit;
        tmo_d      = tmo_q | timeout_hit;
        nak_d      = nak_q;
        cnt_d      = cnt_q;
        snd_load   = 1'b0;
        snd_bytes  = '0;
        snd_count  = '0;
        case (state_q)
            ST_IDLE: begin
                if (new_rx_data) begin
                    if (rx_data == OPC_RUN) begin
                        opcode_d   = OPC_RUN;
                        byte_idx_d = '0;
                        gap_d      = GAP_LOAD;
                        state_d    = ST_RX_PAYLOAD;
                    end else begin
                        snd_load  = 1'b1;
                        snd_count = 3'd1;
                        ping_d    = (rx_data == OPC_PING);
                        snd_bytes = {24'h0, (rx_data == OPC_PING) ? ACK_CHAR : NAK_CHAR};
                        nak_d     = nak_q | (rx_data != OPC_PING);
                        state_d   = ST_TX_ONE;
                    end
                end
            end
            ST_RX_PAYLOAD: begin
                if (new_rx_data) begin
                    operand_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
                    gap_d      = GAP_LOAD;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'(PAYLOAD_BYTES - 1)) begin
                        state_d = ST_DISPATCH;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            ST_DISPATCH: state_d = ST_WAIT_CORE;
            ST_WAIT_CORE: begin
                if (core_done) begin
                    snd_load  = 1'b1;
                    snd_bytes = core_result;
                    snd_count = 3'(PAYLOAD_BYTES);
                    state_d   = ST_TX_RESP;
                end
            end
            ST_TX_RESP: begin
                if (snd_done) begin
                    cnt_d   = cnt_q + 4'd1;
                    state_d = ST_IDLE;
                end
            end
            ST_TX_ONE: begin
                if (snd_done) begin
                    if (ping_q) cnt_d = cnt_q + 4'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs and event decode shared with the next-state logic
    always_comb begin
        overrun_hit = new_rx_data &&
                      (state_q inside {ST_DISPATCH, ST_WAIT_CORE, ST_TX_RESP, ST_TX_ONE});
        timeout_hit = (state_q == ST_RX_PAYLOAD) && !new_rx_data && (gap_q == '0);
        core_start  = (state_q == ST_DISPATCH);
        error       = overrun_hit | timeout_hit;
    end

    assign core_opcode  = opcode_q;
    assign core_operand = operand_q;
    assign ledout       = {ovr_q, tmo_q, nak_q, 1'b0, cnt_q};

endmodule

// File: tb/tb_serial_cmd_sequencer.sv
// Directed bench for serial_cmd_sequencer with a short frame timeout.
module tb_serial_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        new_rx_data;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        tx_busy;
    logic        core_start;
    logic [7:0]  core_opcode;
    logic [31:0] core_operand;
    logic        core_done;
    logic [31:0] core_result;
    logic        error;
    logic [7:0]  ledout;

    serial_cmd_sequencer #(.TIMEOUT_CYC(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .new_rx_data  (new_rx_data),
        .tx_data      (tx_data),
        .new_tx_data  (new_tx_data),
        .tx_busy      (tx_busy),
        .core_start   (core_start),
        .core_opcode  (core_opcode),
        .core_operand (core_operand),
        .core_done    (core_done),
        .core_result  (core_result),
        .error        (error),
        .ledout       (ledout)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] txq[$];
    int         start_cnt = 0;
    int         err_cnt = 0;
    int         err_cyc = 0;
    int         busy_viol = 0;
    int         guard_viol = 0;
    int         last_strobe = -10;
    int         last_rx_cyc = 0;
    int         busy_len = 0;
    int         snap;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe DUT outputs mid-cycle
    always @(negedge clk) begin
        if (new_tx_data) begin
            txq.push_back(tx_data);
            if (tx_busy) busy_viol++;
            if (cyc == last_strobe + 1) guard_viol++;
            last_strobe = cyc;
        end
        if (core_start) start_cnt++;
        if (error) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    // Transmitter model: busy for busy_len cycles starting the cycle after a strobe
    initial begin
        forever begin
            @(negedge clk);
            if (new_tx_data && busy_len > 0) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] e);
        logic [8:0] g;
        if (txq.size() > 0) g = {1'b0, txq.pop_front()};
        else g = 9'h100;
        check(tag, {55'd0, g}, {55'd0, 1'b0, e});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data     = b;
        new_rx_data = 1'b1;
        last_rx_cyc = cyc;
        tick(1);
        new_rx_data = 1'b0;
    endtask

    task automatic core_reply(input logic [31:0] r);
        core_result = r;
        core_done   = 1'b1;
        tick(1);
        core_done   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; new_rx_data = 1'b0; tx_busy = 1'b0;
        core_done = 1'b0; core_result = 32'h0;
        tick(3);

        check("rst_tx_data", tx_data, 8'h00);
        check("rst_new_tx", new_tx_data, 1'b0);
        check("rst_core_start", core_start, 1'b0);
        check("rst_opcode", core_opcode, 8'h00);
        check("rst_operand", core_operand, 32'h0);
        check("rst_error", error, 1'b0);
        check("rst_ledout", ledout, 8'h00);
        rst = 1'b0;
        tick(2);

        // RUN with idle transmitter
        send_byte(8'h68); send_byte(8'hB1); send_byte(8'h08); send_byte(8'h00); send_byte(8'h00);
        check("run1_start", core_start, 1'b1);
        check("run1_operand", core_operand, 32'h0000_08B1);
        check("run1_opcode", core_opcode, 8'h68);
        tick(1);
        check("run1_start_once", core_start, 1'b0);
        tick(3);
        core_reply(32'h1234_5678);
        check("run1_first_strobe", new_tx_data, 1'b1);
        check("run1_first_byte", tx_data, 8'h78);
        tick(12);
        expect_tx("run1_b0", 8'h78);
        expect_tx("run1_b1", 8'h56);
        expect_tx("run1_b2", 8'h34);
        expect_tx("run1_b3", 8'h12);
        check("run1_txq_empty", txq.size(), 0);
        check("run1_led", ledout, 8'h01);

        // RUN with a slow transmitter
        busy_len = 20;
        snap = start_cnt;
        send_byte(8'h68); send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
        check("run2_operand", core_operand, 32'hFFFF_FF01);
        tick(2);
        core_reply(32'hDEAD_BEEF);
        tick(120);
        expect_tx("run2_b0", 8'hEF);
        expect_tx("run2_b1", 8'hBE);
        expect_tx("run2_b2", 8'hAD);
        expect_tx("run2_b3", 8'hDE);
        check("run2_txq_empty", txq.size(), 0);
        check("run2_starts", start_cnt - snap, 1);
        check("run2_busy_viol", busy_viol, 0);
        check("run2_led", ledout, 8'h02);
        busy_len = 0;
        tick(5);

        // Ping and unknown opcode
        snap = start_cnt;
        send_byte(8'h70);
        tick(6);
        expect_tx("ping_ack", 8'h6B);
        check("ping_no_start", start_cnt - snap, 0);
        check("ping_led", ledout, 8'h03);
        send_byte(8'h7A);
        tick(6);
        expect_tx("nak_char", 8'h3F);
        check("nak_led", ledout, 8'h23);

        // Frame timeout after two payload bytes
        snap = err_cnt;
        send_byte(8'h68); send_byte(8'h01); send_byte(8'h02);
        tick(25);
        check("tmo_err_count", err_cnt - snap, 1);
        check("tmo_err_cycle", err_cyc - last_rx_cyc, 16);
        check("tmo_no_tx", txq.size(), 0);
        check("tmo_led", ledout, 8'h63);
        send_byte(8'h70);
        tick(6);
        expect_tx("tmo_ping_ack", 8'h6B);
        check("tmo_ping_led", ledout, 8'h64);

        // Overrun while waiting on the core
        snap = err_cnt;
        send_byte(8'h68); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        tick(2);
        send_byte(8'h55);
        check("ovr_err_count", err_cnt - snap, 1);
        check("ovr_operand", core_operand, 32'h4433_2211);
        tick(2);
        core_reply(32'hCAFE_F00D);
        tick(12);
        expect_tx("ovr_b0", 8'h0D);
        expect_tx("ovr_b1", 8'hF0);
        expect_tx("ovr_b2", 8'hFE);
        expect_tx("ovr_b3", 8'hCA);
        check("ovr_led", ledout, 8'hE5);

        // Reset while waiting on the core, then a stale core_done
        send_byte(8'h68); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        core_reply(32'h0BAD_0BAD);
        tick(10);
        check("rstwait_no_tx", txq.size(), 0);
        check("rstwait_led", ledout, 8'h00);
        check("rstwait_operand", core_operand, 32'h0);

        // 17 pings wrap the command counter
        for (int i = 0; i < 17; i++) begin
            send_byte(8'h70);
            tick(4);
        end
        tick(4);
        check("wrap_tx_count", txq.size(), 17);
        check("wrap_led", ledout, 8'h01);
        check("guard_viol", guard_viol, 0);
        check("busy_viol_all", busy_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
